reg_file_arbiter: RTL and testbench
===================================

Name: reg_file_arbiter

Overview:
- Two-requester access controller for the 32x32 dual-read register file.
- Requester 0 (control unit) and requester 1 (debug/load port) each issue a read-pair or a write through a REQ/ACK handshake.
- The block serialises those transactions onto the register file's READ/WRITE/address/data pins and obeys its strobe rules: READ and WRITE are never both 1, and read data is valid only while READ=1 and WRITE=0.

Parameters:
DATA_WIDTH, 32, register word width
ADDR_WIDTH, 5, register address width

Ports:
CLK  input  1  system clock; all state changes on posedge
RST  input  1  asynchronous, active-low reset
REQ  input  2  REQ[i]=1: requester i has a pending transaction
OP  input  2  OP[i]=1 write, 0 read; for requester i
RADDR1  input  2*ADDR_WIDTH  read address 1; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
RADDR2  input  2*ADDR_WIDTH  read address 2; packed as RADDR1
WADDR  input  2*ADDR_WIDTH  write address; packed as RADDR1
WDATA  input  2*DATA_WIDTH  write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
ACK  output  2  one-cycle completion pulse per requester
RDATA1  output  DATA_WIDTH  captured read data 1; valid when ACK[i]=1 after a read
RDATA2  output  DATA_WIDTH  captured read data 2
BUSY  output  1  1 in every state except IDLE
RF_READ  output  1  register-file READ strobe
RF_WRITE  output  1  register-file WRITE strobe
RF_ADDR_R1  output  ADDR_WIDTH  register-file ADDR_R1
RF_ADDR_R2  output  ADDR_WIDTH  register-file ADDR_R2
RF_ADDR_W  output  ADDR_WIDTH  register-file ADDR_W
RF_DATA_W  output  DATA_WIDTH  register-file DATA_W
RF_DATA_R1  input  DATA_WIDTH  register-file DATA_R1; Z when not reading
RF_DATA_R2  input  DATA_WIDTH  register-file DATA_R2

Behaviour:
- One clock, CLK; reset RST is asynchronous and active-low.
- While RST=0:
  - state=IDLE, priority pointer=0.
  - ACK, RF_READ, RF_WRITE, BUSY, RDATA1, RDATA2 and all RF_ADDR/RF_DATA_W outputs are 0.
  - Any in-flight transaction is abandoned; no ACK is ever issued for it.
- States: IDLE, RD1, RD2, WR, RESP. All outputs are registered (Moore).
- IDLE:
  - At posedge, if any REQ is high, grant one requester g (see arbitration).
  - Latch OP[g], RADDR1/2, WADDR and WDATA of g into internal registers. The requester's later changes do not affect the transaction.
  - Next state is WR if OP[g]=1, else RD1.
- RD1: RF_READ=1, RF_WRITE=0, RF_ADDR_R1/R2 = latched addresses. The register file latches its data at the closing edge. Next state RD2.
- RD2: RF_READ=1 and addresses held. At the closing edge, capture RF_DATA_R1/R2 into RDATA1/RDATA2. Next state RESP.
- WR: RF_WRITE=1, RF_READ=0, RF_ADDR_W/RF_DATA_W = latched values. The write commits at the closing edge. Next state RESP.
- RESP: RF_READ=RF_WRITE=0, ACK[g]=1 for exactly one cycle. Next state IDLE.
- Latency, counted from the IDLE edge that samples REQ high to the ACK-high cycle:
  - read: 3 cycles;
  - write: 2 cycles.
- Handshake rules:
  - The requester holds REQ until it sees ACK and drops REQ at the edge closing the ACK cycle.
  - REQ still high at the first IDLE edge after RESP is a new transaction.
  - Minimum spacing: one IDLE cycle between transactions.
- RDATA1/RDATA2 hold their last captured value through writes and idle periods; they change only at an RD2 closing edge.
- RF_ADDR_*/RF_DATA_W hold the last driven values in IDLE/RESP. Their values are irrelevant there because both strobes are 0.
- Invariant: RF_READ and RF_WRITE are never 1 in the same cycle.
- REQ dropped while that requester is mid-transaction: the transaction still completes and ACK still pulses.
- Both REQ bits high in the same IDLE cycle: arbitration picks one. The loser waits and is granted at the next IDLE edge if its REQ is still high.

Optional Feature:
- Macro RF_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit pointer records the last granted requester (reset 0, meaning requester 1 is preferred first). On simultaneous REQ, grant the requester not granted last. A single REQ is always granted.
- Undefined: fixed priority, requester 0 always wins ties. The pointer logic is absent.

Test Plan:
- Reset, then REQ[1]=1, OP[1]=1, WADDR=3, WDATA=32'hDEADBEEF -> RF_WRITE=1 for exactly one cycle with RF_ADDR_W=3; ACK[1] pulses 2 cycles after grant.
- Then REQ[0]=1, OP[0]=0, RADDR1=3, RADDR2=0 -> RF_READ high for 2 cycles; ACK[0] pulses 3 cycles after grant; RDATA1=32'hDEADBEEF, RDATA2=0.
- Both REQ high, both reads, held through three transactions:
  - macro defined -> ACK order 1,0,1;
  - macro undefined -> 0,0,0 with requester 1 starved.
- Assert RST=0 asynchronously during RD2 -> RF_READ, ACK and RDATA drop to 0 immediately; no ACK after release; state IDLE.
- Change WDATA/WADDR of the granted requester during WR -> the register file receives the latched values; a later read of that address returns the originally requested data.
- Every cycle of all tests: assert !(RF_READ && RF_WRITE), and assert ACK is at most one-hot and at most 1 cycle wide.

Source files
------------

// File: rtl/reg_file_arbiter_if.sv
// Requester-side bus of reg_file_arbiter: two requesters packed side by side.
//
// Handshake: a requester raises REQ[i] with OP/addresses/data stable and
// keeps it high until it sees ACK[i]=1. ACK[i] is a one-cycle pulse. The
// requester drops REQ[i] at the clock edge that closes the ACK cycle. Fields
// are latched at grant, so later changes do not affect a transaction already
// in flight. Dropping REQ mid-transaction does not cancel it.
interface reg_file_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [1:0]              REQ;
  logic [1:0]              OP;
  logic [2*ADDR_WIDTH-1:0] RADDR1;
  logic [2*ADDR_WIDTH-1:0] RADDR2;
  logic [2*ADDR_WIDTH-1:0] WADDR;
  logic [2*DATA_WIDTH-1:0] WDATA;
  logic [1:0]              ACK;
  logic [DATA_WIDTH-1:0]   RDATA1;
  logic [DATA_WIDTH-1:0]   RDATA2;
  logic                    BUSY;

  modport master (
    output REQ, OP, RADDR1, RADDR2, WADDR, WDATA,
    input  ACK, RDATA1, RDATA2, BUSY
  );

  modport slave (
    input  REQ, OP, RADDR1, RADDR2, WADDR, WDATA,
    output ACK, RDATA1, RDATA2, BUSY
  );
endinterface

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: serialises two requesters onto a 32x32 dual-read
// register file. Reads take RD1+RD2 (data captured at the end of RD2),
// writes take one WR cycle, then one RESP cycle carries the ACK pulse.
// All outputs are registered, decoded from the next state.
// Optional macro RF_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of
// fixed priority (requester 0 wins ties).
module reg_file_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  reg_file_arbiter_if.slave     bus,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic [2:0]            STATE_DBG
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic                  take;
  logic                  gnt_d, gnt_q;
  logic                  op_sel;
  logic [ADDR_WIDTH-1:0] raddr1_sel, raddr2_sel, waddr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  logic                  rf_read_d, rf_write_d, busy_d;
  logic [1:0]            ack_d;
  logic                  rf_read_q, rf_write_q, busy_q;
  logic [1:0]            ack_q;
  logic [ADDR_WIDTH-1:0] rf_addr_r1_q, rf_addr_r2_q, rf_addr_w_q;
  logic [DATA_WIDTH-1:0] rf_data_w_q, rdata1_q, rdata2_q;

  assign take = (state_q == S_IDLE) && (|bus.REQ);

`ifdef RF_ARB_ROUND_ROBIN_EN
  // Last granted requester; 0 after reset so requester 1 wins the first tie.
  logic last_q;

  // Tie goes to the requester not granted last; a lone request always wins.
  always_comb begin
    if (&bus.REQ) gnt_d = ~last_q;
    else          gnt_d = ~bus.REQ[0];
  end

  // Remember who was granted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      last_q <= 1'b0;
    else if (take) last_q <= gnt_d;
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    gnt_d = ~bus.REQ[0];
  end
`endif

  // Fields of the granted requester.
  assign op_sel     = bus.OP[gnt_d];
  assign raddr1_sel = gnt_d ? bus.RADDR1[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.RADDR1[ADDR_WIDTH-1:0];
  assign raddr2_sel = gnt_d ? bus.RADDR2[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.RADDR2[ADDR_WIDTH-1:0];
  assign waddr_sel  = gnt_d ? bus.WADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]  : bus.WADDR[ADDR_WIDTH-1:0];
  assign wdata_sel  = gnt_d ? bus.WDATA[2*DATA_WIDTH-1:DATA_WIDTH]  : bus.WDATA[DATA_WIDTH-1:0];

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (take) state_d = op_sel ? S_WR : S_RD1;
      S_RD1:  state_d = S_RD2;
      S_RD2:  state_d = S_RESP;
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    rf_read_d  = (state_d == S_RD1) || (state_d == S_RD2);
    rf_write_d = (state_d == S_WR);
    busy_d     = (state_d != S_IDLE);
    ack_d      = 2'b00;
    if (state_d == S_RESP) ack_d = gnt_q ? 2'b10 : 2'b01;
  end

  // Registered strobes, ACK and BUSY; reset abandons any transaction.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rf_read_q  <= 1'b0;
      rf_write_q <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 2'b00;
    end else begin
      rf_read_q  <= rf_read_d;
      rf_write_q <= rf_write_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  // Grant latch, register-file address/data, and read-data capture at end of RD2.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gnt_q        <= 1'b0;
      rf_addr_r1_q <= '0;
      rf_addr_r2_q <= '0;
      rf_addr_w_q  <= '0;
      rf_data_w_q  <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
    end else begin
      if (take) begin
        gnt_q <= gnt_d;
        if (op_sel) begin
          rf_addr_w_q <= waddr_sel;
          rf_data_w_q <= wdata_sel;
        end else begin
          rf_addr_r1_q <= raddr1_sel;
          rf_addr_r2_q <= raddr2_sel;
        end
      end
      if (state_q == S_RD2) begin
        rdata1_q <= RF_DATA_R1;
        rdata2_q <= RF_DATA_R2;
      end
    end
  end

  assign RF_READ    = rf_read_q;
  assign RF_WRITE   = rf_write_q;
  assign RF_ADDR_R1 = rf_addr_r1_q;
  assign RF_ADDR_R2 = rf_addr_r2_q;
  assign RF_ADDR_W  = rf_addr_w_q;
  assign RF_DATA_W  = rf_data_w_q;
  assign bus.ACK    = ack_q;
  assign bus.BUSY   = busy_q;
  assign bus.RDATA1 = rdata1_q;
  assign bus.RDATA2 = rdata2_q;
  assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: behavioural register file, transaction-level
// reference memory, per-scenario tasks and a per-cycle protocol monitor.
module tb_reg_file_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RF_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // Clock and reset
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  reg_file_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          RF_READ, RF_WRITE;
  logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [DW-1:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
  logic [2:0]    STATE_DBG;

  reg_file_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .STATE_DBG(STATE_DBG)
  );

  // Behavioural register file and transaction-level reference memory
  logic [DW-1:0] rf_mem  [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_q[$];
  int            model_last;

  assign RF_DATA_R1 = (RF_READ && !RF_WRITE) ? rf_mem[RF_ADDR_R1] : 'z;
  assign RF_DATA_R2 = (RF_READ && !RF_WRITE) ? rf_mem[RF_ADDR_R2] : 'z;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    forever begin
      @(posedge CLK);
      if (RST && RF_WRITE) rf_mem[RF_ADDR_W] = RF_DATA_W;
    end
  end

  int checks = 0;
  int failures = 0;
  int rd_cycles, wr_cycles;
  logic [AW-1:0] last_wa;
  logic [DW-1:0] last_wd;
  logic [1:0]    prev_ack;

  // Per-cycle protocol monitor
  initial begin
    prev_ack = 2'b00;
    forever begin
      @(negedge CLK);
      if (RST) begin
        checks++;
        if (RF_READ && RF_WRITE) begin
          failures++;
          $display("FAIL strobe_excl: RF_READ=%b RF_WRITE=%b required not both 1 @%0t", RF_READ, RF_WRITE, $time);
        end
        checks++;
        if ($countones(bus.ACK) > 1 || (bus.ACK != 2'b00 && prev_ack != 2'b00)) begin
          failures++;
          $display("FAIL ack_shape: ACK=%b prev=%b required one-hot single-cycle @%0t", bus.ACK, prev_ack, $time);
        end
        if (RF_READ) rd_cycles++;
        if (RF_WRITE) begin
          wr_cycles++;
          last_wa = RF_ADDR_W;
          last_wd = RF_DATA_W;
        end
        prev_ack = bus.ACK;
      end else begin
        prev_ack = 2'b00;
      end
    end
  end

  // Driver tasks
  task automatic idle_inputs();
    bus.REQ = 2'b00; bus.OP = 2'b00;
    bus.RADDR1 = '0; bus.RADDR2 = '0; bus.WADDR = '0; bus.WDATA = '0;
  endtask

  // One transaction from requester r; called just after a posedge with the DUT idle.
  task automatic run_txn(input int r, input bit op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit drop_early);
    int lat;
    bit got;
    logic [DW-1:0] e1, e2;
    logic [1:0] exp_ack;
    bus.OP[r] = op;
    bus.RADDR1[r*AW +: AW] = a1;
    bus.RADDR2[r*AW +: AW] = a2;
    bus.WADDR[r*AW +: AW]  = wa;
    bus.WDATA[r*DW +: DW]  = wd;
    bus.REQ[r] = 1'b1;
    if (op) ref_mem[wa] = wd;
    else begin
      exp_q.push_back(ref_mem[a1]);
      exp_q.push_back(ref_mem[a2]);
    end
    model_last = r;
    exp_ack = (r == 1) ? 2'b10 : 2'b01;
    rd_cycles = 0; wr_cycles = 0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (drop_early && lat == 1) bus.REQ[r] = 1'b0;
      if (bus.ACK != 2'b00) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL txn_timeout: req=%0d op=%0d no ACK within 12 cycles", r, op);
    end
    checks++;
    if (bus.ACK !== exp_ack) begin
      failures++;
      $display("FAIL txn_ack: ACK=%b required %b", bus.ACK, exp_ack);
    end
    checks++;
    if (lat != (op ? 2 : 3)) begin
      failures++;
      $display("FAIL txn_latency: req=%0d op=%0d got %0d required %0d", r, op, lat, op ? 2 : 3);
    end
    if (op) begin
      checks++;
      if (wr_cycles != 1 || rd_cycles != 0 || last_wa !== wa || last_wd !== wd) begin
        failures++;
        $display("FAIL txn_write: wr=%0d rd=%0d addr=%0d data=%h required 1 0 %0d %h",
                 wr_cycles, rd_cycles, last_wa, last_wd, wa, wd);
      end
    end else begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      checks++;
      if (bus.RDATA1 !== e1 || bus.RDATA2 !== e2) begin
        failures++;
        $display("FAIL txn_rdata: got %h %h required %h %h", bus.RDATA1, bus.RDATA2, e1, e2);
      end
      checks++;
      if (rd_cycles != 2 || wr_cycles != 0) begin
        failures++;
        $display("FAIL txn_read_strobe: rd=%0d wr=%0d required 2 0", rd_cycles, wr_cycles);
      end
    end
    @(posedge CLK); #1;
    bus.REQ[r] = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    model_last = 0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (bus.ACK !== 2'b00 || RF_READ !== 1'b0 || RF_WRITE !== 1'b0 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ACK=%b RD=%b WR=%b BUSY=%b required all 0", bus.ACK, RF_READ, RF_WRITE, bus.BUSY);
    end
    checks++;
    if (bus.RDATA1 !== '0 || bus.RDATA2 !== '0) begin
      failures++;
      $display("FAIL reset_rdata: %h %h required 0 0", bus.RDATA1, bus.RDATA2);
    end
    checks++;
    if (RF_ADDR_R1 !== '0 || RF_ADDR_R2 !== '0 || RF_ADDR_W !== '0 || RF_DATA_W !== '0) begin
      failures++;
      $display("FAIL reset_rf_bus: %0d %0d %0d %h required 0", RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W);
    end
    checks++;
    if (STATE_DBG !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: %0d required 0 (IDLE)", STATE_DBG);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_then_read();
    run_txn(1, 1'b1, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF, 1'b0);
    run_txn(0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic test_arbitration();
    logic [AW-1:0] a1 [2];
    logic [AW-1:0] a2 [2];
    int n_ack, cyc, last_cyc, g, w;
    for (int r = 0; r < 2; r++) begin
      a1[r] = AW'($urandom_range(0, 31));
      a2[r] = AW'($urandom_range(0, 31));
      bus.RADDR1[r*AW +: AW] = a1[r];
      bus.RADDR2[r*AW +: AW] = a2[r];
    end
    bus.OP = 2'b00;
    bus.REQ = 2'b11;
    n_ack = 0; cyc = 0; last_cyc = -1;
    while (n_ack < 3 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (bus.ACK != 2'b00) begin
        g = (RR_EN) ? 1 - model_last : 0;
        model_last = g;
        w = bus.ACK[1] ? 1 : 0;
        checks++;
        if (bus.ACK !== ((g == 1) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL arb_order: ack #%0d ACK=%b required requester %0d", n_ack, bus.ACK, g);
        end
        checks++;
        if (bus.RDATA1 !== ref_mem[a1[w]] || bus.RDATA2 !== ref_mem[a2[w]]) begin
          failures++;
          $display("FAIL arb_rdata: got %h %h required %h %h", bus.RDATA1, bus.RDATA2, ref_mem[a1[w]], ref_mem[a2[w]]);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 4) begin
            failures++;
            $display("FAIL arb_spacing: gap %0d required 4", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n_ack++;
      end
    end
    checks++;
    if (n_ack != 3) begin
      failures++;
      $display("FAIL arb_timeout: %0d ACKs required 3", n_ack);
    end
    @(posedge CLK); #1;
    bus.REQ = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid_read();
    int seen;
    bus.OP[0] = 1'b0;
    bus.RADDR1[AW-1:0] = 5'd3;
    bus.RADDR2[AW-1:0] = AW'($urandom_range(0, 31));
    bus.REQ[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (RF_READ !== 1'b1 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: RD=%b BUSY=%b required 1 1", RF_READ, bus.BUSY);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (RF_READ !== 1'b0 || bus.ACK !== 2'b00 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ctrl: RD=%b ACK=%b BUSY=%b required 0", RF_READ, bus.ACK, bus.BUSY);
    end
    checks++;
    if (bus.RDATA1 !== '0 || bus.RDATA2 !== '0 || STATE_DBG !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid_data: %h %h state=%0d required 0 0 0", bus.RDATA1, bus.RDATA2, STATE_DBG);
    end
    bus.REQ = 2'b00;
    model_last = 0;
    @(posedge CLK);
    #2 RST = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (bus.ACK != 2'b00) seen++;
    end
    checks++;
    if (seen != 0 || STATE_DBG !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid_after: %0d stray ACKs state=%0d required 0 0", seen, STATE_DBG);
    end
  endtask

  task automatic test_latch_write();
    int r;
    logic [AW-1:0] a, decoy;
    logic [DW-1:0] d, d2;
    r = $urandom_range(0, 1);
    a = AW'($urandom_range(1, 31));
    decoy = ~a;
    d = $urandom;
    d2 = ~d;
    bus.OP[r] = 1'b1;
    bus.WADDR[r*AW +: AW] = a;
    bus.WDATA[r*DW +: DW] = d;
    bus.REQ[r] = 1'b1;
    ref_mem[a] = d;
    model_last = r;
    @(posedge CLK); #1;
    bus.WADDR[r*AW +: AW] = decoy;
    bus.WDATA[r*DW +: DW] = d2;
    #1;
    checks++;
    if (RF_WRITE !== 1'b1 || RF_ADDR_W !== a || RF_DATA_W !== d) begin
      failures++;
      $display("FAIL latch_wr: WR=%b addr=%0d data=%h required 1 %0d %h", RF_WRITE, RF_ADDR_W, RF_DATA_W, a, d);
    end
    @(posedge CLK); #1;
    checks++;
    if (bus.ACK !== ((r == 1) ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL latch_ack: ACK=%b required requester %0d", bus.ACK, r);
    end
    @(posedge CLK); #1;
    bus.REQ[r] = 1'b0;
    run_txn(r, 1'b0, a, decoy, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
              AW'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_arbitration();
    test_reset_mid_read();
    test_latch_write();
    test_random();
    test_arbitration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
